// File: rtl/fibonacci_server_if.sv
// Request/response bundle for the shared Fibonacci engine: two requesters in,
// one tagged response out.
interface fibonacci_server_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = 6
);
    logic             req0_valid;
    logic [IDX_W-1:0] req0_idx;
    logic             req0_ready;
    logic             req1_valid;
    logic [IDX_W-1:0] req1_idx;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [W-1:0]     rsp_num;
    logic             rsp_ovf;
    logic             busy;

    modport master (
        output req0_valid, req0_idx, req1_valid, req1_idx, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_num, rsp_ovf, busy
    );

    modport slave (
        input  req0_valid, req0_idx, req1_valid, req1_idx, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_num, rsp_ovf, busy
    );
endinterface

// File: rtl/fibonacci_server.sv
// Shared Fibonacci engine: round-robin grant between two requesters, one
// adder step per cycle, tagged response with overflow flag.
module fibonacci_server #(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = 6
) (
    input logic               clk,
    input logic               rst,
    fibonacci_server_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t           state, state_nx;
    logic             prio;
    logic             id_q;
    logic [W-1:0]     a, b;
    logic             a_ovf, b_ovf;
    logic [IDX_W-1:0] cnt;
    logic             rsp_valid_q;
    logic [W-1:0]     rsp_num_q;
    logic             rsp_ovf_q;
    logic             busy_q;

    logic             grant_c;
    logic             accept_c;
    logic [W:0]       sum_c;

    // Both valid: pointer decides; otherwise the lone valid requester wins.
    assign grant_c  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    assign accept_c = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign sum_c    = {1'b0, a} + {1'b0, b};

    assign bus.req0_ready = rst && accept_c && !grant_c;
    assign bus.req1_ready = rst && accept_c && grant_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_num    = rsp_num_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.busy       = busy_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            id_q        <= 1'b0;
            a           <= '0;
            b           <= '0;
            a_ovf       <= 1'b0;
            b_ovf       <= 1'b0;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_num_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        cnt   <= grant_c ? bus.req1_idx : bus.req0_idx;
                        id_q  <= grant_c;
                        a     <= '0;
                        b     <= W'(1);
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        rsp_num_q   <= a;
                        rsp_ovf_q   <= a_ovf;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        // a_ovf follows the term that becomes a; b's own overflow stays hidden until then
                        a     <= b;
                        b     <= sum_c[W-1:0];
                        a_ovf <= b_ovf;
                        b_ovf <= b_ovf | a_ovf | sum_c[W];
                        cnt   <= cnt - IDX_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        prio        <= ~id_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fibonacci_server.md
Name: fibonacci_server

Overview:
- Shared Fibonacci compute engine for two requesters.
- Each requester submits an index n over a valid/ready handshake. A round-robin arbiter grants one request at a time.
- An iterative single-adder datapath advances one Fibonacci step per cycle. F(n) is returned on a response channel tagged with the requester id and an overflow flag.
- Sits between request sources (test sequencers, CPU-side register block) and the shared adder datapath of the sequential-basics Fibonacci generators.

Parameters:
- W, 16, data width of Fibonacci terms and of rsp_num.
- IDX_W, 6, width of the requested index; supports n = 0 .. 2^IDX_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req0_valid  input  1  requester 0 has a request.
- req0_idx  input  IDX_W  requester 0 index n.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid  input  1  requester 1 has a request.
- req1_idx  input  IDX_W  requester 1 index n.
- req1_ready  output  1  requester 1 request accepted this cycle.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester the response belongs to.
- rsp_num  output  W  F(n) mod 2^W.
- rsp_ovf  output  1  F(n) exceeded W bits.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Sequence definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Reset (rst=0, asynchronous):
  - FSM -> IDLE; round-robin pointer -> requester 0 has priority.
  - Outputs: rsp_valid=0, rsp_id=0, rsp_num=0, rsp_ovf=0, busy=0, req0_ready=0, req1_ready=0.
  - Internal registers a, b, cnt and the overflow flags cleared.
  - Reset mid-operation discards the in-flight request; no response is produced for it.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - reqX_ready is combinational and asserted only for the granted requester, only in IDLE.
  - Grant: if exactly one reqX_valid is high, that requester wins. If both are high, the requester named by the priority pointer wins.
  - Accepting edge (valid && ready): latch idx into cnt, latch id, set a=0, b=1, a_ovf=0, b_ovf=0; go to RUN.
- RUN:
  - If cnt==0: rsp_num<=a, rsp_ovf<=a_ovf; go to RESP.
  - Else: a<=b; b<=(a+b) truncated to W; a_ovf<=b_ovf; b_ovf<=b_ovf|a_ovf|carry_out(a+b); cnt<=cnt-1.
  - The overflow flag tracks only terms that become the result. Overflow of the look-ahead term b alone never sets rsp_ovf.
- RESP:
  - rsp_valid=1; rsp_id, rsp_num and rsp_ovf are held stable until the rsp_ready handshake.
  - On handshake: go to IDLE; priority pointer -> the requester not just served.
  - No new grant in the handshake cycle.
- Latency: rsp_valid rises n+1 edges after the accepting edge. For n=0, rsp_valid rises 1 edge after accept.
- Minimum spacing between accepts is n+3 cycles: 1 accept + (n+1) RUN + 1 RESP with rsp_ready held high.
- Requests not granted remain pending; requesters keep valid and idx stable until ready.
- Outputs are unchanged while rsp_ready=0 indefinitely (backpressure).

Test Plan:
- Reset, then req0 n=0 with rsp_ready=1 -> rsp_valid 1 edge after accept; rsp_num=0, rsp_ovf=0, rsp_id=0.
- req1 n=10 -> rsp_valid exactly 11 edges after accept; rsp_num=55, rsp_id=1, rsp_ovf=0.
- Boundary at W=16:
  - n=24 -> rsp_num=46368, rsp_ovf=0.
  - n=25 -> rsp_num=9489 (75025 mod 65536), rsp_ovf=1.
  - n=63 -> rsp_ovf=1, rsp_num=F(63) mod 2^16.
- Both requesters valid continuously (req0 n=5, req1 n=7) -> grants alternate 0,1,0,1 starting with 0. Responses 5,13,5,13 with matching rsp_id; each reqX_ready is one cycle wide and asserted only in IDLE.
- Hold rsp_ready=0 for 20 cycles during RESP -> rsp_valid, rsp_num and rsp_id stay constant. The other requester's ready stays 0 and busy=1 throughout. After release, return to IDLE, then grant the other requester.
- Assert rst=0 asynchronously mid-RUN for n=20 -> outputs clear immediately without a clock edge. No response is ever issued for that request. After release, a new req0 n=3 returns 2.
